// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: condition codes and flag layout.
// Imported by the interface, the condition evaluator and the top module.
package branch_pkg;

   typedef logic [3:0] flags_t;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [3:0] {
      COND_NEVER  = 4'b0000,
      COND_EQ     = 4'b0001,
      COND_LT     = 4'b0010,
      COND_LE     = 4'b0011,
      COND_ALWAYS = 4'b0100,
      COND_NE     = 4'b0101,
      COND_GE     = 4'b0110,
      COND_GT     = 4'b0111,
      COND_HS     = 4'b1000,
      COND_LO     = 4'b1001,
      COND_LS     = 4'b1010,
      COND_HI     = 4'b1011,
      COND_VS     = 4'b1100,
      COND_VC     = 4'b1101,
      COND_NSET   = 4'b1110,
      COND_NCLR   = 4'b1111
   } cond_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle of flag-write, branch-request and result signals of the unit.
// slave = branch unit side, master = ALU/decode/fetch side.
interface branch_resolve_unit_if
   import branch_pkg::*;
#(
   parameter int PC_W  = 8,
   parameter int OFF_W = 8,
   parameter int CNT_W = 16
);
   logic             flag_we;
   flags_t           flag_in;
   logic             br_valid;
   logic             br_ready;
   cond_t            br_cond;
   logic [PC_W-1:0]  br_pc;
   logic [OFF_W-1:0] br_offset;
   logic             flush;
   logic             res_valid;
   logic             res_ready;
   logic             res_taken;
   logic [PC_W-1:0]  res_target;
   flags_t           flags_q;
   logic [CNT_W-1:0] taken_count;

   modport slave (
      input  flag_we, flag_in, br_valid, br_cond, br_pc, br_offset,
      input  flush, res_ready,
      output br_ready, res_valid, res_taken, res_target,
      output flags_q, taken_count
   );

   modport master (
      output flag_we, flag_in, br_valid, br_cond, br_pc, br_offset,
      output flush, res_ready,
      input  br_ready, res_valid, res_taken, res_target,
      input  flags_q, taken_count
   );
endinterface

// File: rtl/branch_resolve_unit_cond.sv
// Combinational condition evaluator: flags + 4-bit code -> taken.
// Ports: flags (Z,N,C,V), cond (cond_t), taken.
module cond_eval
   import branch_pkg::*;
(
   input  flags_t flags,
   input  cond_t  cond,
   output logic   taken
);
   logic z, n, c, v, lt;

   assign z  = flags[FLAG_Z];
   assign n  = flags[FLAG_N];
   assign c  = flags[FLAG_C];
   assign v  = flags[FLAG_V];
   assign lt = n ^ v;

   always_comb begin
      taken = 1'b0;
      unique case (cond)
         COND_NEVER:  taken = 1'b0;
         COND_EQ:     taken = z;
         COND_LT:     taken = lt;
         COND_LE:     taken = z | lt;
         COND_ALWAYS: taken = 1'b1;
         COND_NE:     taken = ~z;
         COND_GE:     taken = ~lt;
         COND_GT:     taken = ~z & ~lt;
         COND_HS:     taken = c;
         COND_LO:     taken = ~c;
         COND_LS:     taken = ~c | z;
         COND_HI:     taken = c & ~z;
         COND_VS:     taken = v;
         COND_VC:     taken = ~v;
         COND_NSET:   taken = n;
         COND_NCLR:   taken = ~n;
      endcase
   end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch decision stage: flag register, condition evaluation, target adder,
// registered result with valid/ready, flush, saturating taken counter.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int PC_W    = 8,
   parameter int OFF_W   = 8,
   parameter int CNT_W   = 16,
   parameter bit FORWARD = 1'b1
)(
   input  logic                 clk,
   input  logic                 rst,
   branch_resolve_unit_if.slave bus
);
   flags_t                  flags_q, flags_d, eff_flags;
   logic                    res_valid_q, res_valid_d;
   logic                    res_taken_q, res_taken_d;
   logic [PC_W-1:0]         res_target_q, res_target_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    taken, accept, br_ready;
   logic signed [PC_W-1:0]  off_sext;
   logic [PC_W-1:0]         tgt_taken, tgt_seq;

   // Same-cycle ALU flag write is visible to the branch only when forwarding.
   assign eff_flags = (FORWARD && bus.flag_we) ? bus.flag_in : flags_q;

   cond_eval u_cond (
      .flags (eff_flags),
      .cond  (bus.br_cond),
      .taken (taken)
   );

   assign off_sext  = PC_W'($signed(bus.br_offset));
   assign tgt_taken = bus.br_pc + off_sext;
   assign tgt_seq   = bus.br_pc + 1'b1;

   assign br_ready = ~bus.flush & (~res_valid_q | bus.res_ready);
   assign accept   = bus.br_valid & br_ready;

   always_comb begin
      flags_d      = flags_q;
      res_valid_d  = res_valid_q;
      res_taken_d  = res_taken_q;
      res_target_d = res_target_q;
      cnt_d        = cnt_q;
      if (bus.flag_we) flags_d = bus.flag_in;
      if (bus.flush) begin
         res_valid_d = 1'b0;
      end else if (accept) begin
         res_valid_d  = 1'b1;
         res_taken_d  = taken;
         res_target_d = taken ? tgt_taken : tgt_seq;
      end else if (bus.res_ready) begin
         res_valid_d = 1'b0;
      end
      if (accept && taken && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q      <= '0;
         res_valid_q  <= 1'b0;
         res_taken_q  <= 1'b0;
         res_target_q <= '0;
         cnt_q        <= '0;
      end else begin
         flags_q      <= flags_d;
         res_valid_q  <= res_valid_d;
         res_taken_q  <= res_taken_d;
         res_target_q <= res_target_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.br_ready    = br_ready;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_taken   = res_taken_q;
   assign bus.res_target  = res_target_q;
   assign bus.flags_q     = flags_q;
   assign bus.taken_count = cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: two units (forwarding/16-bit count, no-forwarding/2-bit
// count) share stimulus; a reference model predicts results per unit.
module tb_branch_resolve_unit;
   import branch_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_resolve_unit_if #(.PC_W(8), .OFF_W(8), .CNT_W(16)) ia ();
   branch_resolve_unit_if #(.PC_W(8), .OFF_W(8), .CNT_W(2))  ib ();

   assign ib.flag_we   = ia.flag_we;
   assign ib.flag_in   = ia.flag_in;
   assign ib.br_valid  = ia.br_valid;
   assign ib.br_cond   = ia.br_cond;
   assign ib.br_pc     = ia.br_pc;
   assign ib.br_offset = ia.br_offset;
   assign ib.flush     = ia.flush;
   assign ib.res_ready = ia.res_ready;

   branch_resolve_unit #(.PC_W(8), .OFF_W(8), .CNT_W(16), .FORWARD(1'b1))
      u_a (.clk(clk), .rst(rst), .bus(ia.slave));
   branch_resolve_unit #(.PC_W(8), .OFF_W(8), .CNT_W(2), .FORWARD(1'b0))
      u_b (.clk(clk), .rst(rst), .bus(ib.slave));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       t1;
      logic [7:0] g1;
      logic       t0;
      logic [7:0] g0;
   } exp_t;
   exp_t q[$];

   logic       mv;
   logic [3:0] mflags;
   int         cnt_a, cnt_b;

   function automatic logic ref_taken(logic [3:0] f, int c);
      logic z, n, cy, v, lt;
      z = f[0]; n = f[1]; cy = f[2]; v = f[3];
      lt = n ^ v;
      case (c)
         0:  return 1'b0;
         1:  return z;
         2:  return lt;
         3:  return z | lt;
         4:  return 1'b1;
         5:  return !z;
         6:  return !lt;
         7:  return !z && !lt;
         8:  return cy;
         9:  return !cy;
         10: return !cy || z;
         11: return cy && !z;
         12: return v;
         13: return !v;
         14: return n;
         default: return !n;
      endcase
   endfunction

   function automatic logic [7:0] ref_target(int pc, int off, logic t);
      int s;
      if (!t) s = pc + 1;
      else s = pc + ((off >= 128) ? off - 256 : off);
      return 8'(s & 255);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor + model: compare at negedge, then advance model for next edge.
   initial begin
      mv = 1'b0; mflags = '0; cnt_a = 0; cnt_b = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mv = 1'b0; mflags = '0; cnt_a = 0; cnt_b = 0;
            q.delete();
         end else begin
            logic exp_rdy, cons, kill, acc, t1, t0;
            logic [3:0] ef;
            exp_t e;
            exp_rdy = !ia.flush && (!mv || ia.res_ready);
            chk("br_ready_a", 32'(ia.br_ready), 32'(exp_rdy));
            chk("br_ready_b", 32'(ib.br_ready), 32'(exp_rdy));
            chk("res_valid_a", 32'(ia.res_valid), 32'(mv));
            chk("res_valid_b", 32'(ib.res_valid), 32'(mv));
            if (mv) begin
               if (q.size() == 0) begin
                  chk("scoreboard_nonempty", 32'(0), 32'(1));
               end else begin
                  chk("res_taken_a", 32'(ia.res_taken), 32'(q[0].t1));
                  chk("res_target_a", 32'(ia.res_target), 32'(q[0].g1));
                  chk("res_taken_b", 32'(ib.res_taken), 32'(q[0].t0));
                  chk("res_target_b", 32'(ib.res_target), 32'(q[0].g0));
               end
            end
            chk("flags_a", 32'(ia.flags_q), 32'(mflags));
            chk("flags_b", 32'(ib.flags_q), 32'(mflags));
            chk("count_a", 32'(ia.taken_count), 32'(cnt_a));
            chk("count_b", 32'(ib.taken_count), 32'(cnt_b));

            cons = mv && ia.res_ready && !ia.flush;
            kill = mv && ia.flush;
            if ((cons || kill) && q.size() > 0) void'(q.pop_front());
            acc = ia.br_valid && exp_rdy;
            if (acc) begin
               ef = ia.flag_we ? ia.flag_in : mflags;
               t1 = ref_taken(ef, int'(ia.br_cond));
               t0 = ref_taken(mflags, int'(ia.br_cond));
               e.t1 = t1;
               e.g1 = ref_target(int'(ia.br_pc), int'(ia.br_offset), t1);
               e.t0 = t0;
               e.g0 = ref_target(int'(ia.br_pc), int'(ia.br_offset), t0);
               q.push_back(e);
               if (t1 && cnt_a < 65535) cnt_a++;
               if (t0 && cnt_b < 3) cnt_b++;
               mv = 1'b1;
            end else if (cons || kill) begin
               mv = 1'b0;
            end
            if (ia.flag_we) mflags = ia.flag_in;
         end
      end
   end

   task automatic drive(logic we, logic [3:0] fin, logic v, int c,
                        int pc, int off, logic rr, logic fl);
      @(posedge clk);
      #2;
      ia.flag_we   = we;
      ia.flag_in   = fin;
      ia.br_valid  = v;
      ia.br_cond   = cond_t'(4'(c));
      ia.br_pc     = 8'(pc);
      ia.br_offset = 8'(off);
      ia.res_ready = rr;
      ia.flush     = fl;
   endtask

   initial begin
      ia.flag_we = 0; ia.flag_in = 0; ia.br_valid = 0;
      ia.br_cond = COND_NEVER; ia.br_pc = 0; ia.br_offset = 0;
      ia.res_ready = 0; ia.flush = 0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // Build up count and a held result, then reset asynchronously.
      repeat (5) drive(0, 4'h0, 1, 4, 8'h05, 3, 1, 0);
      drive(0, 4'h0, 1, 4, 8'h06, 3, 0, 0);
      drive(0, 4'h0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_res_valid", 32'(ia.res_valid), 32'(0));
      chk("rst_res_taken", 32'(ia.res_taken), 32'(0));
      chk("rst_res_target", 32'(ia.res_target), 32'(0));
      chk("rst_flags", 32'(ia.flags_q), 32'(0));
      chk("rst_count", 32'(ia.taken_count), 32'(0));
      chk("rst_count_b", 32'(ib.taken_count), 32'(0));
      @(posedge clk);
      #2 rst = 1'b0;

      // Z set, EQ, negative offset.
      drive(1, 4'b0001, 0, 0, 0, 0, 1, 0);
      drive(0, 4'b0000, 1, 1, 8'h10, 8'hFE, 1, 0);
      // Unsigned compares with C=1, Z=0, including PC wrap.
      drive(1, 4'b0100, 0, 0, 0, 0, 1, 0);
      drive(0, 4'b0000, 1, 11, 8'h20, 8'h08, 1, 0);
      drive(0, 4'b0000, 1, 10, 8'h30, 8'h08, 1, 0);
      drive(0, 4'b0000, 1, 10, 8'hFF, 8'h08, 1, 0);
      // Forwarding: clear flags, then write Z in the same cycle as EQ branch.
      drive(1, 4'b0000, 0, 0, 0, 0, 1, 0);
      drive(1, 4'b0001, 1, 1, 8'h40, 8'h04, 1, 0);
      // Backpressure: hold result for three cycles, then stream.
      drive(0, 4'b0000, 1, 4, 8'h50, 8'h10, 0, 0);
      repeat (3) drive(0, 4'b0000, 1, 4, 8'h60, 8'h10, 0, 0);
      drive(0, 4'b0000, 1, 4, 8'h60, 8'h10, 1, 0);
      drive(0, 4'b0000, 0, 0, 0, 0, 1, 0);
      // Flush with a pending result and a valid request.
      drive(0, 4'b0000, 1, 4, 8'h70, 8'h02, 0, 0);
      drive(0, 4'b0000, 1, 4, 8'h80, 8'h02, 1, 1);
      drive(0, 4'b0000, 0, 0, 0, 0, 1, 0);
      // Saturate the 2-bit counter.
      repeat (4) drive(0, 4'b0000, 1, 4, 8'h90, 8'h01, 1, 0);

      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 9) < 3, 4'($urandom),
               $urandom_range(0, 9) < 7, int'($urandom_range(0, 15)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      end
      repeat (3) drive(0, 4'b0000, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Next-generation branch decision block for the 88bit core.
- Holds an architectural flag register (Z, N, C, V) written by the ALU.
- Evaluates a 4-bit condition code against those flags and computes the branch target.
- Presents a registered taken/target result to fetch over a valid/ready handshake.
- Adds unsigned and overflow conditions, flag forwarding, flush, and a taken-branch counter.

Parameters:
- PC_W, 8, program-counter width in bits.
- OFF_W, 8, branch offset width, two's complement; OFF_W <= PC_W is required.
- CNT_W, 16, width of the saturating taken-branch counter.
- FORWARD, 1, when 1 a same-cycle flag write is visible to the branch being accepted; when 0 the old flags are used.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flag_we  in  1  write enable for the flag register.
- flag_in  in  4  new flags {V,C,N,Z}, Z at bit 0.
- br_valid  in  1  branch request valid.
- br_ready  out  1  unit can accept a request.
- br_cond  in  4  condition code.
- br_pc  in  PC_W  PC of the branch instruction.
- br_offset  in  OFF_W  signed relative offset.
- flush  in  1  kill any pending result and block acceptance this cycle.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_taken  out  1  branch taken.
- res_target  out  PC_W  next PC.
- flags_q  out  4  current flag register.
- taken_count  out  CNT_W  number of taken branches, saturating.

Behaviour:
- Reset (asynchronous, active-high) clears to 0: flags_q, res_valid, res_taken, res_target, taken_count.
- Flag register: on flag_we, flags_q <= flag_in at the clock edge. Flush does not affect flags.
- Effective flags for evaluation: flag_in when FORWARD=1 and flag_we=1, otherwise flags_q.
- Condition codes, with lt = N^V:
  - 0000 never; 0001 Z; 0010 lt; 0011 Z|lt.
  - 0100 always; 0101 ~Z; 0110 ~lt; 0111 ~Z&~lt.
  - 1000 C (unsigned >=); 1001 ~C (unsigned <); 1010 ~C|Z (unsigned <=); 1011 C&~Z (unsigned >).
  - 1100 V; 1101 ~V; 1110 N; 1111 ~N.
- Codes 0000-0111 keep the legacy 3-bit meanings (compare-to-zero semantics when V=0).
- br_ready = ~flush & (~res_valid | res_ready). This is combinational and does not depend on br_valid.
- Accept: occurs when br_valid & br_ready. On the next edge:
  - res_valid <= 1;
  - res_taken <= cond result;
  - res_target <= taken ? br_pc + sext(br_offset) : br_pc + 1.
  - Addition is modulo 2^PC_W; wrap-around is silent.
- Latency: one cycle from accept to res_valid.
- Full-throughput streaming is supported: a result consumed and a new request accepted in the same cycle is allowed.
- Hold: while res_valid & ~res_ready, all res_* outputs stay stable and br_ready = 0.
- Consume without a new accept: res_valid <= 0. res_taken and res_target keep their values, which are don't-care.
- Flush: res_valid <= 0 at the next edge, no accept occurs, and flush overrides res_ready.
- taken_count: increments by 1 on each accepted taken branch and saturates at all-ones. A flush after accept does not decrement it.
- Reset mid-operation: all state clears immediately; an in-flight result is lost.

Decomposition:
- Shared package branch_pkg holds:
  - typedef cond_t, a 4-bit enum with the sixteen codes (COND_NEVER ... COND_NCLR);
  - flag bit index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3;
  - typedef flags_t (4 bits).
- One combinational sub-module, cond_eval (flags_t, cond_t -> taken), instantiated once. It is reusable for conditional moves.
- The handshake register stage, counter and target adder stay in the top module.

Test Plan:
- Reset while res_valid=1 and taken_count=5 -> all outputs read 0 immediately, before the next clock edge.
- Flags {V,C,N,Z}=0001, cond 0001, br_pc=0x10, offset=0xFE -> next cycle res_valid=1, res_taken=1, res_target=0x0E, taken_count=1.
- Unsigned compares with flags C=1, Z=0: cond 1011 -> taken; cond 1010 -> not taken, res_target=br_pc+1. PC=0xFF not taken -> target 0x00 (wrap).
- Forwarding: flags_q=0000, same cycle flag_we with flag_in=0001 and cond 0001:
  - FORWARD=1 -> taken;
  - FORWARD=0 -> not taken;
  - both cases -> flags_q=0001 afterwards.
- Backpressure: res_ready=0 for 3 cycles with br_valid held -> br_ready=0 and res_* stable. Then res_ready=1 -> the next request is accepted in the same cycle, back-to-back.
- Flush with res_valid=1 and br_valid=1 -> br_ready=0, res_valid=0 next cycle, flags unchanged. With CNT_W=2, four taken branches -> taken_count saturates at 3.
